// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the UART receive and transmit halves.
//   rx_state_e  : receiver FSM state encoding (also visible on the debug bus)
//   OVERSAMPLE  : sample ticks per bit period
//   MID_START   : sample index at which the start bit is re-checked
//   MID_BIT     : sample index at which data and stop bits are captured
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        START    = 3'd1,
        DATA     = 3'd2,
        STOP     = 3'd3,
        BRK_WAIT = 3'd4
    } rx_state_e;

    localparam int OVERSAMPLE = 16;
    localparam int MID_START  = 7;
    localparam int MID_BIT    = 15;

endpackage

// File: rtl/uart_rx_if.sv
// ---------------------------------------------------------------------------
// uart_rx_if
// Bundle between the UART receiver and its RX FIFO / LSR logic.
//
// Handshake: fifo_wr_en is a single-cycle push of fifo_wr_data with no
// backpressure beyond fifo_full. The receiver samples fifo_full only at the
// mid-stop-bit decision; if it is high there the byte is dropped and
// overrun_o pulses instead of fifo_wr_en. frame_err_o, break_o and overrun_o
// are single-cycle pulses aligned with the cycle the byte would be written.
// fifo_wr_data holds its last written value between pushes.
//
// Signals:
//   fifo_full    FIFO -> RX  FIFO cannot accept a write this cycle
//   fifo_wr_en   RX -> FIFO  push strobe
//   fifo_wr_data RX -> FIFO  received byte
//   frame_err_o  RX -> LSR   stop bit sampled low
//   break_o      RX -> LSR   all-zero data with low stop bit
//   overrun_o    RX -> LSR   complete byte dropped because FIFO was full
//   busy_o       RX -> top   receiver not idle
//   state        RX -> dbg   current receiver FSM state
// ---------------------------------------------------------------------------
interface uart_rx_if;
    import uart_pkg::*;

    logic       fifo_full;
    logic       fifo_wr_en;
    logic [7:0] fifo_wr_data;
    logic       frame_err_o;
    logic       break_o;
    logic       overrun_o;
    logic       busy_o;
    rx_state_e  state;

    modport master (
        input  fifo_full,
        output fifo_wr_en,
        output fifo_wr_data,
        output frame_err_o,
        output break_o,
        output overrun_o,
        output busy_o,
        output state
    );

    modport slave (
        output fifo_full,
        input  fifo_wr_en,
        input  fifo_wr_data,
        input  frame_err_o,
        input  break_o,
        input  overrun_o,
        input  busy_o,
        input  state
    );

endinterface

// File: rtl/uart_baud_gen.sv
// ---------------------------------------------------------------------------
// uart_baud_gen
// Oversampling tick generator. Counts 0..divisor-1 and emits sample_tick for
// one clock when the count reaches divisor-1. A zero divisor stops ticks.
// The divisor is used live, so shrinking it below the current count simply
// wraps the counter without a tick.
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   divisor      16-bit baud divisor {DLM, DLL}
//   sample_tick  one-clock strobe at 16x the baud rate
// ---------------------------------------------------------------------------
module uart_baud_gen (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] divisor,
    output logic        sample_tick
);

    logic [15:0] tick_cnt;
    logic [15:0] last_cnt;

    assign last_cnt    = divisor - 16'd1;
    assign sample_tick = (divisor != 16'd0) && (tick_cnt == last_cnt);

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt <= 16'd0;
        end else if ((divisor == 16'd0) || (tick_cnt >= last_cnt)) begin
            tick_cnt <= 16'd0;
        end else begin
            tick_cnt <= tick_cnt + 16'd1;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// 8N1 serial receiver. rx_i is synchronised, oversampled at 16x the baud
// rate, start bit re-validated at mid-bit, data captured LSB first at
// mid-bit, and each completed byte pushed into the RX FIFO together with
// framing-error / break / overrun status pulses.
// Ports:
//   clk, rst   system clock, synchronous active-high reset
//   DLM, DLL   baud divisor high / low byte
//   rx_i       asynchronous serial input, idle high
//   rx_bus     FIFO push, status pulses, busy and debug state (uart_rx_if)
// ---------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int OVERSAMPLE  = uart_pkg::OVERSAMPLE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] DLM,
    input  logic [7:0] DLL,
    input  logic       rx_i,
    uart_rx_if.master  rx_bus
);

    localparam int SCW = $clog2(OVERSAMPLE);
    localparam logic [SCW-1:0] START_SAMPLE = SCW'(MID_START);
    localparam logic [SCW-1:0] BIT_SAMPLE   = SCW'(MID_BIT);

    // ------------------------------------------------------------------
    // Baud tick
    // ------------------------------------------------------------------
    logic sample_tick;

    uart_baud_gen u_baud_gen (
        .clk         (clk),
        .rst         (rst),
        .divisor     ({DLM, DLL}),
        .sample_tick (sample_tick)
    );

    // ------------------------------------------------------------------
    // Synchroniser: resets to the idle (high) line level so a reset never
    // looks like a start edge.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Receiver FSM
    // ------------------------------------------------------------------
    rx_state_e      state, state_n;
    logic [SCW-1:0] sample_cnt, sample_cnt_n;
    logic [2:0]     bit_cnt, bit_cnt_n;
    logic [7:0]     shift_q, shift_n;
    logic [7:0]     wr_data_q, wr_data_n;
    logic           wr_en_q, wr_en_n;
    logic           ferr_q, ferr_n;
    logic           brk_q, brk_n;
    logic           ovr_q, ovr_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sample_cnt <= '0;
            bit_cnt    <= '0;
            shift_q    <= '0;
            wr_data_q  <= '0;
            wr_en_q    <= 1'b0;
            ferr_q     <= 1'b0;
            brk_q      <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state      <= state_n;
            sample_cnt <= sample_cnt_n;
            bit_cnt    <= bit_cnt_n;
            shift_q    <= shift_n;
            wr_data_q  <= wr_data_n;
            wr_en_q    <= wr_en_n;
            ferr_q     <= ferr_n;
            brk_q      <= brk_n;
            ovr_q      <= ovr_n;
        end
    end

    always_comb begin
        state_n      = state;
        sample_cnt_n = sample_cnt;
        bit_cnt_n    = bit_cnt;
        shift_n      = shift_q;
        wr_data_n    = wr_data_q;
        wr_en_n      = 1'b0;
        ferr_n       = 1'b0;
        brk_n        = 1'b0;
        ovr_n        = 1'b0;

        // Every decision is gated by the oversample tick; a zero divisor
        // therefore freezes the FSM wherever it is.
        if (sample_tick) begin
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state_n      = START;
                        sample_cnt_n = '0;
                    end
                end

                START: begin
                    if (sample_cnt == START_SAMPLE) begin
                        sample_cnt_n = '0;
                        bit_cnt_n    = '0;
                        // Line back high at mid start bit: treat as noise.
                        state_n      = rx_s ? IDLE : DATA;
                    end else begin
                        sample_cnt_n = sample_cnt + 1'b1;
                    end
                end

                DATA: begin
                    // The counter wraps to 0 naturally after the mid-bit
                    // sample, which keeps consecutive bits 16 ticks apart.
                    sample_cnt_n = sample_cnt + 1'b1;
                    if (sample_cnt == BIT_SAMPLE) begin
                        shift_n   = {rx_s, shift_q[7:1]};
                        bit_cnt_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state_n      = STOP;
                            sample_cnt_n = '0;
                        end
                    end
                end

                STOP: begin
                    sample_cnt_n = sample_cnt + 1'b1;
                    if (sample_cnt == BIT_SAMPLE) begin
                        sample_cnt_n = '0;
                        wr_en_n      = !rx_bus.fifo_full;
                        ovr_n        = rx_bus.fifo_full;
                        if (!rx_bus.fifo_full) begin
                            wr_data_n = shift_q;
                        end
                        ferr_n  = !rx_s;
                        brk_n   = !rx_s && (shift_q == 8'h00);
                        // A low stop bit means the line may stay low (break);
                        // wait for it to return high before looking for a start.
                        state_n = rx_s ? IDLE : BRK_WAIT;
                    end
                end

                BRK_WAIT: begin
                    if (rx_s) begin
                        state_n = IDLE;
                    end
                end

                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign rx_bus.fifo_wr_en   = wr_en_q;
    assign rx_bus.fifo_wr_data = wr_data_q;
    assign rx_bus.frame_err_o  = ferr_q;
    assign rx_bus.break_o      = brk_q;
    assign rx_bus.overrun_o    = ovr_q;
    assign rx_bus.busy_o       = (state != IDLE);
    assign rx_bus.state        = state;

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
// Directed bench for uart_rx. Each frame driven pushes its expected
// FIFO/status event {wr, ferr, brk, ovr, data} into exp_q; a monitor on the
// falling edge pops and compares whenever the receiver emits anything.
// ---------------------------------------------------------------------------
module tb_uart_rx;
    import uart_pkg::*;

    localparam int EW = 12;

    logic       clk;
    logic       rst;
    logic [7:0] dlm;
    logic [7:0] dll;
    logic       rx_i;

    uart_rx_if dut_if ();

    uart_rx #(
        .SYNC_STAGES (2),
        .OVERSAMPLE  (16)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .DLM    (dlm),
        .DLL    (dll),
        .rx_i   (rx_i),
        .rx_bus (dut_if.master)
    );

    // ---------------- clock / reset / cycle counter ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int last_wr_cyc = -1;
    logic prev_pulse = 1'b0;

    function automatic logic [EW-1:0] ev(input logic wr, input logic ferr,
                                         input logic brk, input logic ovr,
                                         input logic [7:0] data);
        return {wr, ferr, brk, ovr, data};
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic          any;
        logic [EW-1:0] act;
        logic [EW-1:0] exp;
        any = dut_if.fifo_wr_en | dut_if.frame_err_o | dut_if.break_o | dut_if.overrun_o;
        if (!rst && any) begin
            act = {dut_if.fifo_wr_en, dut_if.frame_err_o, dut_if.break_o,
                   dut_if.overrun_o, dut_if.fifo_wr_en ? dut_if.fifo_wr_data : 8'h00};
            if (dut_if.fifo_wr_en) last_wr_cyc = cyc;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_event: got %h expected none", act);
            end else begin
                exp = exp_q.pop_front();
                if (act !== exp) begin
                    n_fail++;
                    $display("FAIL rx_event: got %h expected %h", act, exp);
                end
            end
            n_checks++;
            if (prev_pulse) begin
                n_fail++;
                $display("FAIL pulse_width: got 2+ cycles expected 1");
            end
        end
        prev_pulse = any;
    end

    // ---------------- driver tasks ----------------
    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                              input int bit_clks);
        rx_i = 1'b0;
        hold(bit_clks);
        for (int i = 0; i < 8; i++) begin
            rx_i = data[i];
            hold(bit_clks);
        end
        rx_i = stop_bit;
        hold(bit_clks);
        rx_i = 1'b1;
        hold(2 * bit_clks);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int start_cyc;
        int lat;
        int budget;

        rst = 1'b1;
        dlm = 8'h00;
        dll = 8'h01;
        rx_i = 1'b1;
        dut_if.fifo_full = 1'b0;
        hold(3);

        // Reset state
        check("rst_wr_en", dut_if.fifo_wr_en, 0);
        check("rst_flags", {dut_if.frame_err_o, dut_if.break_o, dut_if.overrun_o}, 0);
        check("rst_busy", dut_if.busy_o, 0);
        check("rst_state", dut_if.state, IDLE);
        rst = 1'b0;
        hold(4);

        // 1: D=1, 0xA5, latency from start edge
        exp_q.push_back(ev(1, 0, 0, 0, 8'hA5));
        start_cyc = cyc;
        send_frame(8'hA5, 1'b1, 16);
        lat = last_wr_cyc - start_cyc;
        check("a5_latency_ok", (lat >= 151 && lat <= 159), 1);
        check("a5_idle_after", dut_if.busy_o, 0);

        // 2: D=3, start glitch of 4 ticks
        dll = 8'h03;
        hold(10);
        rx_i = 1'b0;
        hold(12);
        rx_i = 1'b1;
        hold(1);
        check("glitch_busy_high", dut_if.busy_o, 1);
        budget = 0;
        while (dut_if.busy_o && budget < 80) begin
            hold(1);
            budget++;
        end
        check("glitch_busy_drop", dut_if.busy_o, 0);
        check("glitch_state", dut_if.state, IDLE);
        hold(60);

        // 3: D=1, framing error
        dll = 8'h01;
        hold(4);
        exp_q.push_back(ev(1, 1, 0, 0, 8'h3C));
        send_frame(8'h3C, 1'b0, 16);

        // 4: long break, then normal frame
        exp_q.push_back(ev(1, 1, 1, 0, 8'h00));
        rx_i = 1'b0;
        hold(20 * 16);
        check("break_state", dut_if.state, BRK_WAIT);
        rx_i = 1'b1;
        hold(32);
        check("break_released", dut_if.state, IDLE);
        exp_q.push_back(ev(1, 0, 0, 0, 8'h81));
        send_frame(8'h81, 1'b1, 16);

        // 5: overrun, then normal, then overrun with framing error
        dut_if.fifo_full = 1'b1;
        exp_q.push_back(ev(0, 0, 0, 1, 8'h00));
        send_frame(8'h55, 1'b1, 16);
        dut_if.fifo_full = 1'b0;
        exp_q.push_back(ev(1, 0, 0, 0, 8'h66));
        send_frame(8'h66, 1'b1, 16);
        dut_if.fifo_full = 1'b1;
        exp_q.push_back(ev(0, 1, 0, 1, 8'h00));
        send_frame(8'h0F, 1'b0, 16);
        dut_if.fifo_full = 1'b0;
        check("held_data", dut_if.fifo_wr_data, 8'h66);

        // 6: reset during bit 4 of 0xFF
        rx_i = 1'b0;
        hold(16);
        rx_i = 1'b1;
        hold(4 * 16 + 8);
        check("pre_rst_state", dut_if.state, DATA);
        rst = 1'b1;
        hold(1);
        rst = 1'b0;
        check("mid_rst_state", dut_if.state, IDLE);
        check("mid_rst_busy", dut_if.busy_o, 0);
        check("mid_rst_outs", {dut_if.fifo_wr_en, dut_if.frame_err_o,
                               dut_if.break_o, dut_if.overrun_o}, 0);
        check("mid_rst_data", dut_if.fifo_wr_data, 8'h00);
        hold(6 * 16);
        exp_q.push_back(ev(1, 0, 0, 0, 8'h12));
        send_frame(8'h12, 1'b1, 16);

        hold(20);
        check("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard time limit in case the stimulus ever stalls.
    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Serial receiver half of the UART. It oversamples rx_i at 16x the baud rate using the {DLM, DLL} divisor and validates the start bit at mid-bit. It deserialises 8N1 frames LSB-first and pushes each received byte into the RX FIFO. Per-frame status pulses (framing error, break, overrun) feed the LSR/interrupt logic in the UART top.

Parameters:
SYNC_STAGES, 2, number of flops in the rx_i metastability synchroniser (min 2)
OVERSAMPLE, 16, sample ticks per bit period (fixed at 16; kept as parameter for the bench only)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
DLM  input  8  baud divisor high byte
DLL  input  8  baud divisor low byte
rx_i  input  1  asynchronous serial input, idle high
fifo_full  input  1  RX FIFO cannot accept a write this cycle
fifo_wr_en  output  1  one-cycle pulse; pushes fifo_wr_data into RX FIFO
fifo_wr_data  output  8  received byte, valid when fifo_wr_en=1
frame_err_o  output  1  one-cycle pulse: stop bit sampled 0
break_o  output  1  one-cycle pulse: data=0x00 and stop bit 0
overrun_o  output  1  one-cycle pulse: complete byte dropped because fifo_full=1
busy_o  output  1  high while state != IDLE

Behaviour:
- Reset (sync, rst=1 at clk edge): state=IDLE; synchroniser flops=1; tick and sample counters=0; shift reg=0; all outputs 0. A reset mid-frame abandons the frame with no write and no status pulse.
- Tick gen: 16-bit divisor D={DLM,DLL}. tick_cnt counts 0..D-1; sample_tick=1 for one clk when tick_cnt==D-1, then wraps to 0. D=0: no ticks; receiver stays in or holds its current state. D is sampled live, so a change mid-frame corrupts only that frame.
- rx_s = synchronised rx_i. All decisions are made only on sample_tick cycles.
- IDLE: if rx_s==0 on a tick -> START with sample_cnt=0.
- START: sample_cnt increments each tick. At sample_cnt==7 (mid start bit): rx_s==0 -> DATA with sample_cnt=0 and bit_cnt=0; rx_s==1 -> IDLE (glitch rejected, no outputs).
- DATA: sample_cnt increments each tick. At sample_cnt==15 (mid bit): shift reg = {rx_s, shift[7:1]} (LSB first) and bit_cnt+1. After the 8th bit -> STOP with sample_cnt=0.
- STOP: at sample_cnt==15 (mid stop bit), evaluate:
  - fifo_full=0 -> fifo_wr_en=1 on the next clk, with fifo_wr_data=shift reg.
  - fifo_full=1 -> no write; overrun_o=1 on the next clk.
  - rx_s==0 -> frame_err_o=1 (the data is still written if there is room).
  - rx_s==0 and shift==0x00 -> break_o=1 as well.
  - Then -> IDLE if rx_s==1, else -> BRK_WAIT.
- BRK_WAIT: stay until rx_s==1 on a tick, then -> IDLE. No new start detection while in BRK_WAIT, so a long break produces exactly one byte.
- Latency: fifo_wr_en asserts 1 clk after the mid-stop tick, i.e. about 9.5 bit periods after the start edge. Pulses are never longer than 1 clk.
- Simultaneous overrun and frame error: both pulses assert in the same cycle.
- fifo_wr_data holds its value between writes.

Decomposition:
- uart_pkg: rx_state_e (IDLE, START, DATA, STOP, BRK_WAIT), OVERSAMPLE=16, MID_START=7, MID_BIT=15. uart_tx shares the constants.
- Sub-module uart_baud_gen (divisor in, sample_tick out), also reused by uart_tx. The synchroniser and FSM stay inline.

Test Plan:
- D=1, send 0xA5 8N1 -> exactly one fifo_wr_en with data 0xA5, about 152 clk after the start edge (±1 tick); frame_err_o, break_o and overrun_o stay 0.
- D=3, rx_i low for 4 ticks then high -> returns to IDLE; no fifo_wr_en; busy_o drops after the mid-start sample.
- D=1, send 0x3C with stop bit forced 0 -> fifo_wr_en with 0x3C and frame_err_o=1 in the same cycle; break_o=0.
- D=1, hold rx_i low for 20 bit periods then release -> one write of 0x00 with frame_err_o=1 and break_o=1; no further writes until rx_i is high, then the next frame is received normally.
- fifo_full=1 during the stop-bit sample of byte 0x55 -> no fifo_wr_en; overrun_o=1 for 1 clk. A following byte 0x66 with fifo_full=0 is written correctly.
- Assert rst for 1 clk during DATA bit 4 of 0xFF -> all outputs 0 and state IDLE on the next clk; no write for that frame; the next byte 0x12 is received correctly.
